// File: rtl/zig_zag_scanner_param_if.sv
// Host-side bus of the zig-zag scanner: start/mode handshake, source load port
// and destination read port.
interface zig_zag_scanner_param_if #(
  parameter int N      = 8,
  parameter int DATA_W = 8,
  parameter int ADDR_W = $clog2(N*N)
) ();
  logic              start;
  logic              mode;
  logic              src_we;
  logic [ADDR_W-1:0] src_waddr;
  logic [DATA_W-1:0] src_wdata;
  logic [ADDR_W-1:0] dst_raddr;
  logic [DATA_W-1:0] dst_rdata;
  logic              busy;
  logic              done;

  modport master (
    output start, mode, src_we, src_waddr, src_wdata, dst_raddr,
    input  dst_rdata, busy, done
  );

  modport slave (
    input  start, mode, src_we, src_waddr, src_wdata, dst_raddr,
    output dst_rdata, busy, done
  );
endinterface

// File: rtl/zig_zag_scanner_param.sv
// N x N zig-zag scanner (mode 0: raster -> zig-zag) and de-scanner
// (mode 1: zig-zag -> raster), one element moved per cycle between two buffers.
module zig_zag_scanner_param #(
  parameter int N      = 8,
  parameter int DATA_W = 8,
  parameter int ADDR_W = $clog2(N*N)
) (
  input logic clk,
  input logic reset,
  zig_zag_scanner_param_if.slave bus
);
  localparam int RC_W = $clog2(2*N-1);
  localparam int NN   = N*N;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] k;
  logic [RC_W-1:0]   r, c, d;
  logic [RC_W-1:0]   r_nxt, c_nxt, d_nxt;
  logic              mode_q;
  logic              last;
  logic [ADDR_W-1:0] rasidx, rd_idx, wr_idx;
  logic [DATA_W-1:0] src_rd;
  int                ri, ci, di, entry;

  logic [DATA_W-1:0] src_mem [NN];
  logic [DATA_W-1:0] dst_mem [NN];

  assign last   = (int'(k) == NN-1);
  assign rasidx = ADDR_W'(int'(r) * N + int'(c));
  assign rd_idx = mode_q ? k : rasidx;
  assign wr_idx = mode_q ? rasidx : k;
  assign src_rd = (int'(rd_idx) < NN) ? src_mem[rd_idx] : '0;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (bus.start) state_nxt = RUN;
      RUN:        if (last)      state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Next zig-zag position; a diagonal edge hops straight to the next
  // diagonal's entry point so there is no bubble between diagonals.
  always_comb begin
    ri    = int'(r);
    ci    = int'(c);
    di    = int'(d);
    entry = (di + 2 > N) ? di + 2 - N : 0;
    d_nxt = d;
    r_nxt = r;
    c_nxt = c;
    if (d[0]) begin
      if (ri == N-1 || ci == 0) begin
        d_nxt = RC_W'(di + 1);
        c_nxt = RC_W'(entry);
        r_nxt = RC_W'(di + 1 - entry);
      end else begin
        r_nxt = RC_W'(ri + 1);
        c_nxt = RC_W'(ci - 1);
      end
    end else begin
      if (ci == N-1 || ri == 0) begin
        d_nxt = RC_W'(di + 1);
        r_nxt = RC_W'(entry);
        c_nxt = RC_W'(di + 1 - entry);
      end else begin
        r_nxt = RC_W'(ri - 1);
        c_nxt = RC_W'(ci + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      k      <= '0;
      r      <= '0;
      c      <= '0;
      d      <= '0;
      mode_q <= 1'b0;
    end else if (state != RUN && bus.start) begin
      k      <= '0;
      r      <= '0;
      c      <= '0;
      d      <= '0;
      mode_q <= bus.mode;
    end else if (state == RUN) begin
      k <= k + 1'b1;
      r <= r_nxt;
      c <= c_nxt;
      d <= d_nxt;
    end
  end

  // Buffers are never cleared; host writes are locked out during a traversal.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == RUN)
        dst_mem[wr_idx] <= src_rd;
      if (state != RUN && bus.src_we && int'(bus.src_waddr) < NN)
        src_mem[bus.src_waddr] <= bus.src_wdata;
    end
  end

  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);
  assign bus.dst_rdata = (int'(bus.dst_raddr) < NN) ? dst_mem[bus.dst_raddr] : '0;
endmodule

// File: tb/tb_zig_zag_scanner_param.sv
// Directed bench for zig_zag_scanner_param at N=8, N=4 (12-bit data) and N=3,
// with a queue of expected destination contents filled when a traversal starts.
module tb_zig_zag_scanner_param;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  zig_zag_scanner_param_if #(.N(8), .DATA_W(8))  b8 ();
  zig_zag_scanner_param_if #(.N(4), .DATA_W(12)) b4 ();
  zig_zag_scanner_param_if #(.N(3), .DATA_W(8))  b3 ();

  zig_zag_scanner_param #(.N(8), .DATA_W(8))  u8 (.clk(clk), .reset(reset), .bus(b8.slave));
  zig_zag_scanner_param #(.N(4), .DATA_W(12)) u4 (.clk(clk), .reset(reset), .bus(b4.slave));
  zig_zag_scanner_param #(.N(3), .DATA_W(8))  u3 (.clk(clk), .reset(reset), .bus(b3.slave));

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q [$];

  int ref8 [16] = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5};
  int ref4 [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
  int ref3 [9]  = '{0, 1, 3, 6, 4, 2, 5, 7, 8};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Raster index of the kk-th element in JPEG zig-zag order, walked diagonal by diagonal.
  function automatic int zz_pos(input int n, input int kk);
    int cnt, lo, hi, r;
    cnt = 0;
    for (int dd = 0; dd <= 2*n-2; dd++) begin
      lo = (dd - n + 1 > 0) ? dd - n + 1 : 0;
      hi = (dd < n - 1) ? dd : n - 1;
      for (int i = 0; i <= hi - lo; i++) begin
        r = (dd % 2 == 1) ? lo + i : hi - i;
        if (cnt == kk) return r * n + (dd - r);
        cnt++;
      end
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int w, input logic st, input logic m, input logic we,
                        input int wa, input int wd);
    case (w)
      8: begin b8.start = st; b8.mode = m; b8.src_we = we; b8.src_waddr = 6'(wa); b8.src_wdata = 8'(wd); end
      4: begin b4.start = st; b4.mode = m; b4.src_we = we; b4.src_waddr = 4'(wa); b4.src_wdata = 12'(wd); end
      default: begin b3.start = st; b3.mode = m; b3.src_we = we; b3.src_waddr = 4'(wa); b3.src_wdata = 8'(wd); end
    endcase
  endtask

  function automatic logic get_busy(input int w);
    return (w == 8) ? b8.busy : (w == 4) ? b4.busy : b3.busy;
  endfunction

  function automatic logic get_done(input int w);
    return (w == 8) ? b8.done : (w == 4) ? b4.done : b3.done;
  endfunction

  task automatic rd(input int w, input int a, output logic [31:0] v);
    case (w)
      8: b8.dst_raddr = 6'(a);
      4: b4.dst_raddr = 4'(a);
      default: b3.dst_raddr = 4'(a);
    endcase
    #1;
    v = (w == 8) ? 32'(b8.dst_rdata) : (w == 4) ? 32'(b4.dst_rdata) : 32'(b3.dst_rdata);
  endtask

  task automatic wr(input int w, input int a, input int v);
    set_in(w, 1'b0, 1'b0, 1'b1, a, v);
    tick();
    set_in(w, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic go(input int w, input logic m);
    set_in(w, 1'b1, m, 1'b0, 0, 0);
    tick();
    set_in(w, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  // t0 is the current cycle number counted from the start edge; lat is the
  // cycle in which done must first be seen.
  task automatic wait_done(input int w, input string tag, input int t0, input int lat);
    int cnt, bcnt;
    cnt  = 0;
    bcnt = 0;
    while (!get_done(w) && cnt < 300) begin
      if (get_busy(w)) bcnt++;
      tick();
      cnt++;
    end
    chk({tag, "_done_cycle"}, t0 + cnt, lat);
    chk({tag, "_busy_cycles"}, bcnt, lat - t0);
    chk({tag, "_busy_low"}, 32'(get_busy(w)), 0);
  endtask

  task automatic drain(input int w, input string tag, input int nn);
    logic [31:0] v, e;
    for (int i = 0; i < nn; i++) begin
      rd(w, i, v);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      chk($sformatf("%s_dst%0d", tag, i), v, e);
    end
  endtask

  task automatic push_fwd8();
    for (int kk = 0; kk < 64; kk++) exp_q.push_back(32'(zz_pos(8, kk)));
  endtask

  initial begin
    logic [31:0] v;
    set_in(8, 0, 0, 0, 0, 0);
    set_in(4, 0, 0, 0, 0, 0);
    set_in(3, 0, 0, 0, 0, 0);
    b8.dst_raddr = '0;
    b4.dst_raddr = '0;
    b3.dst_raddr = '0;
    repeat (3) tick();
    chk("rst_busy8", 32'(b8.busy), 0);
    chk("rst_done8", 32'(b8.done), 0);
    chk("rst_busy4", 32'(b4.busy), 0);
    chk("rst_done4", 32'(b4.done), 0);
    chk("rst_busy3", 32'(b3.busy), 0);
    chk("rst_done3", 32'(b3.done), 0);
    reset = 1'b1;
    tick();

    // N=8 forward, src[i]=i
    for (int i = 0; i < 64; i++) wr(8, i, i);
    push_fwd8();
    go(8, 1'b0);
    chk("fwd8_busy_c1", 32'(b8.busy), 1);
    wait_done(8, "fwd8", 1, 65);
    drain(8, "fwd8", 64);
    for (int i = 0; i < 16; i++) begin
      rd(8, i, v);
      chk($sformatf("fwd8_ref%0d", i), v, ref8[i]);
    end
    rd(8, 63, v);
    chk("fwd8_ref63", v, 63);

    // N=8 inverse of the forward result restores raster order
    for (int i = 0; i < 64; i++) wr(8, i, zz_pos(8, i));
    for (int i = 0; i < 64; i++) exp_q.push_back(32'(i));
    go(8, 1'b1);
    wait_done(8, "inv8", 1, 65);
    drain(8, "inv8", 64);

    // N=8 forward with start/mode/src_we pulsed mid-run: all ignored
    for (int i = 0; i < 64; i++) wr(8, i, i);
    push_fwd8();
    go(8, 1'b0);
    repeat (19) tick();
    set_in(8, 1'b1, 1'b1, 1'b1, 5, 'hFF);
    tick();
    set_in(8, 1'b0, 1'b0, 1'b0, 0, 0);
    wait_done(8, "ign8", 21, 65);
    drain(8, "ign8", 64);
    push_fwd8();
    go(8, 1'b0);
    wait_done(8, "ign8b", 1, 65);
    drain(8, "ign8b", 64);

    // N=8 reset at RUN cycle 30, then a clean rerun
    go(8, 1'b0);
    repeat (29) tick();
    chk("rst8_busy_pre", 32'(b8.busy), 1);
    reset = 1'b0;
    tick();
    chk("rst8_busy", 32'(b8.busy), 0);
    chk("rst8_done", 32'(b8.done), 0);
    reset = 1'b1;
    tick();
    push_fwd8();
    go(8, 1'b0);
    wait_done(8, "rerun8", 1, 65);
    drain(8, "rerun8", 64);

    // N=4, 12-bit data
    for (int i = 0; i < 16; i++) wr(4, i, i + 'h100);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'('h100 + ref4[i]));
    go(4, 1'b0);
    wait_done(4, "fwd4", 1, 17);
    drain(4, "fwd4", 16);

    // N=3, out-of-range write dropped and read returns 0
    for (int i = 0; i < 9; i++) wr(3, i, i);
    wr(3, 12, 'h55);
    for (int i = 0; i < 9; i++) exp_q.push_back(32'(ref3[i]));
    go(3, 1'b0);
    wait_done(3, "fwd3", 1, 10);
    drain(3, "fwd3", 9);
    rd(3, 12, v);
    chk("fwd3_oob_rd", v, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
